// File: rtl/elpis_ctrl_pkg.sv
// Shared op-codes, sequencer states and default widths for the Elpis boot sequencer.
package elpis_ctrl_pkg;

    localparam int DEF_ADDR_W     = 20;
    localparam int DEF_DATA_W     = 32;
    localparam int DEF_FIFO_DEPTH = 4;
    localparam int DEF_RESET_HOLD = 8;

    localparam logic [1:0] OP_NOP   = 2'b00;
    localparam logic [1:0] OP_LOAD  = 2'b01;
    localparam logic [1:0] OP_START = 2'b10;
    localparam logic [1:0] OP_HALT  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_HOLD = 2'd2,
        S_RUN  = 2'd3
    } state_t;

    // Saturating increment for the 16-bit load counter.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/elpis_out_fifo.sv
// Show-ahead synchronous FIFO with clear; a push on a full FIFO is accepted only
// when a pop frees a slot in the same cycle, otherwise it raises an overflow pulse.
module elpis_out_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              full,
    output logic              empty,
    output logic              overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              push_ok;
    logic              pop_ok;

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign pop_ok   = pop && !clr && !empty;
    assign push_ok  = push && !clr && (!full || pop);
    assign overflow = push && !clr && full && !pop;
    assign rdata    = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; clear wins over any same-cycle push/pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(push_ok) - CNT_W'(pop_ok);
        end
    end

    // Storage array write port.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/elpis_boot_sequencer.sv
// Host-driven boot sequencer for the Elpis core: loads program words while the core
// is held in reset, releases reset after a fixed hold, and buffers core output words.
module elpis_boot_sequencer
    import elpis_ctrl_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int RESET_HOLD = DEF_RESET_HOLD
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              host_valid,
    output logic              host_ready,
    input  logic [1:0]        host_op,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              core_reset,
    output logic              core_loading,
    output logic              core_mem_we,
    output logic [ADDR_W-1:0] core_mem_addr,
    output logic [DATA_W-1:0] core_mem_data,
    input  logic              core_out_valid,
    input  logic [DATA_W-1:0] core_out_data,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    input  logic              rd_ready,
    output logic [1:0]        state,
    output logic              overflow,
    output logic              cmd_err,
    output logic [15:0]       load_count
);

    localparam int HOLD_W = $clog2(RESET_HOLD + 1);

    state_t            state_q, state_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic              core_reset_q;
    logic              loading_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic              overflow_q;
    logic              cmd_err_q;
    logic [15:0]       load_count_q;

    logic accept;
    logic latch_load;
    logic fifo_clr;
    logic cmd_err_set;
    logic fifo_push;
    logic fifo_full;
    logic fifo_empty;
    logic fifo_ovf;

    assign host_ready    = (state_q == S_IDLE) || (state_q == S_RUN);
    assign accept        = host_valid && host_ready;
    assign fifo_push     = core_out_valid && (state_q == S_RUN);
    assign core_reset    = core_reset_q;
    assign core_loading  = loading_q;
    assign core_mem_we   = loading_q;
    assign core_mem_addr = addr_q;
    assign core_mem_data = data_q;
    assign rd_valid      = !fifo_empty;
    assign state         = state_q;
    assign overflow      = overflow_q;
    assign cmd_err       = cmd_err_q;
    assign load_count    = load_count_q;

    // Next-state decode; the hold counter is loaded with RESET_HOLD and RUN is entered
    // on the edge after it reaches zero, so reset drops RESET_HOLD+1 edges after START.
    always_comb begin
        state_d     = state_q;
        hold_cnt_d  = hold_cnt_q;
        latch_load  = 1'b0;
        fifo_clr    = 1'b0;
        cmd_err_set = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept && host_op == OP_LOAD) begin
                    latch_load = 1'b1;
                    state_d    = S_LOAD;
                end else if (accept && host_op == OP_START) begin
                    fifo_clr   = 1'b1;
                    hold_cnt_d = HOLD_W'(RESET_HOLD);
                    state_d    = S_HOLD;
                end
            end
            S_LOAD: state_d = S_IDLE;
            S_HOLD: begin
                if (hold_cnt_q == '0) state_d = S_RUN;
                else                  hold_cnt_d = hold_cnt_q - HOLD_W'(1);
            end
            S_RUN: begin
                if (accept && host_op == OP_HALT) state_d = S_IDLE;
                if (accept && (host_op == OP_LOAD || host_op == OP_START)) cmd_err_set = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State register and core control strobes, registered from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            hold_cnt_q   <= '0;
            core_reset_q <= 1'b1;
            loading_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_cnt_q   <= hold_cnt_d;
            core_reset_q <= (state_d != S_RUN);
            loading_q    <= (state_d == S_LOAD);
        end
    end

    // Write address/data capture and status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q       <= '0;
            data_q       <= '0;
            overflow_q   <= 1'b0;
            cmd_err_q    <= 1'b0;
            load_count_q <= '0;
        end else begin
            if (latch_load) begin
                addr_q <= host_addr;
                data_q <= host_wdata;
            end
            if (state_q == S_LOAD) load_count_q <= sat_inc16(load_count_q);
            if (fifo_ovf)          overflow_q   <= 1'b1;
            if (cmd_err_set)       cmd_err_q    <= 1'b1;
        end
    end

    elpis_out_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_out_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (fifo_clr),
        .push     (fifo_push),
        .pop      (rd_ready),
        .wdata    (core_out_data),
        .rdata    (rd_data),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .overflow (fifo_ovf)
    );

endmodule

// File: tb/tb_elpis_boot_sequencer.sv
// Self-checking bench for elpis_boot_sequencer against a queue-based reference model.
module tb_elpis_boot_sequencer;

    localparam int ADDR_W = 20;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 4;
    localparam int HOLD   = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              host_valid;
    logic              host_ready;
    logic [1:0]        host_op;
    logic [ADDR_W-1:0] host_addr;
    logic [DATA_W-1:0] host_wdata;
    logic              core_reset;
    logic              core_loading;
    logic              core_mem_we;
    logic [ADDR_W-1:0] core_mem_addr;
    logic [DATA_W-1:0] core_mem_data;
    logic              core_out_valid;
    logic [DATA_W-1:0] core_out_data;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic              rd_ready;
    logic [1:0]        state;
    logic              overflow;
    logic              cmd_err;
    logic [15:0]       load_count;

    always #5 clk = ~clk;

    elpis_boot_sequencer #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (DEPTH),
        .RESET_HOLD (HOLD)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .host_valid     (host_valid),
        .host_ready     (host_ready),
        .host_op        (host_op),
        .host_addr      (host_addr),
        .host_wdata     (host_wdata),
        .core_reset     (core_reset),
        .core_loading   (core_loading),
        .core_mem_we    (core_mem_we),
        .core_mem_addr  (core_mem_addr),
        .core_mem_data  (core_mem_data),
        .core_out_valid (core_out_valid),
        .core_out_data  (core_out_data),
        .rd_valid       (rd_valid),
        .rd_data        (rd_data),
        .rd_ready       (rd_ready),
        .state          (state),
        .overflow       (overflow),
        .cmd_err        (cmd_err),
        .load_count     (load_count)
    );

    int vectors = 0;
    int errors  = 0;

    // Reference model: FIFO contents, sticky flags, run mode, load tally.
    logic [DATA_W-1:0] mq[$];
    logic              m_ovf;
    logic              m_err;
    logic              m_run;
    int                m_loads;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        mq.delete();
        m_ovf   = 1'b0;
        m_err   = 1'b0;
        m_run   = 1'b0;
        m_loads = 0;
    endtask

    task automatic do_reset();
        rst_n          = 1'b0;
        host_valid     = 1'b0;
        host_op        = 2'b00;
        host_addr      = '0;
        host_wdata     = '0;
        core_out_valid = 1'b0;
        core_out_data  = '0;
        rd_ready       = 1'b0;
        model_reset();
        #2;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Presents a command and returns #1 after the edge on which it was accepted.
    task automatic send_cmd(input logic [1:0] op, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        int n = 0;
        host_valid = 1'b1;
        host_op    = op;
        host_addr  = a;
        host_wdata = d;
        while (!host_ready && n < 50) begin
            step();
            n++;
        end
        vectors++;
        if (host_ready !== 1'b1) begin
            errors++;
            $display("FAIL cmd_accept_timeout: host_ready=%b required 1 (op=%0d)", host_ready, op);
        end
        step();
        host_valid = 1'b0;
        host_op    = 2'b00;
    endtask

    // One clock of core/host FIFO traffic, mirrored into the model queue.
    task automatic drive_cycle(input logic v, input logic [DATA_W-1:0] d, input logic r);
        logic was_full;
        logic pop;
        core_out_valid = v;
        core_out_data  = d;
        rd_ready       = r;
        was_full = (mq.size() == DEPTH);
        pop      = r && (mq.size() > 0);
        if (pop) void'(mq.pop_front());
        if (v && m_run) begin
            if (was_full && !pop) m_ovf = 1'b1;
            else                  mq.push_back(d);
        end
        step();
        core_out_valid = 1'b0;
        rd_ready       = 1'b0;
    endtask

    task automatic go_run();
        do_reset();
        send_cmd(2'b10, '0, '0);
        repeat (HOLD + 1) step();
        m_run = 1'b1;
        vectors++;
        if (state !== 2'd3) begin
            errors++;
            $display("FAIL enter_run: state=%0d required 3", state);
        end
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if ({core_reset, core_loading, core_mem_we, rd_valid, overflow, cmd_err, host_ready} !== 7'b1000001
            || state !== 2'd0 || load_count !== 16'd0 || core_mem_addr !== '0 || core_mem_data !== '0) begin
            errors++;
            $display("FAIL reset_state: rst=%b ld=%b we=%b rv=%b ov=%b ce=%b hr=%b st=%0d lc=%0d required 1,0,0,0,0,0,1,0,0",
                     core_reset, core_loading, core_mem_we, rd_valid, overflow, cmd_err, host_ready, state, load_count);
        end
        go_run();
        for (int i = 1; i <= 5; i++) drive_cycle(1'b1, DATA_W'(i), 1'b0);
        send_cmd(2'b01, 20'h00123, 32'h1);
        vectors++;
        if (overflow !== 1'b1 || cmd_err !== 1'b1 || rd_valid !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_flags: ov=%b ce=%b rv=%b required 1,1,1", overflow, cmd_err, rd_valid);
        end
        #3;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (core_reset !== 1'b1 || state !== 2'd0 || rd_valid !== 1'b0 || overflow !== 1'b0 || cmd_err !== 1'b0) begin
            errors++;
            $display("FAIL async_reset_midrun: rst=%b st=%0d rv=%b ov=%b ce=%b required 1,0,0,0,0",
                     core_reset, state, rd_valid, overflow, cmd_err);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_load();
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
        do_reset();
        for (int i = 0; i < 16; i++) begin
            a = (i == 0) ? 20'h00010 : ADDR_W'($urandom);
            d = (i == 0) ? 32'hDEADBEEF : $urandom;
            send_cmd(2'b01, a, d);
            m_loads++;
            vectors++;
            if (core_mem_we !== 1'b1 || core_loading !== 1'b1 || core_reset !== 1'b1 || state !== 2'd1
                || host_ready !== 1'b0 || core_mem_addr !== a || core_mem_data !== d) begin
                errors++;
                $display("FAIL load_write: we=%b ld=%b rst=%b st=%0d hr=%b addr=%h data=%h required 1,1,1,1,0 addr=%h data=%h",
                         core_mem_we, core_loading, core_reset, state, host_ready, core_mem_addr, core_mem_data, a, d);
            end
            step();
            vectors++;
            if (core_mem_we !== 1'b0 || core_loading !== 1'b0 || state !== 2'd0 || load_count !== 16'(m_loads)) begin
                errors++;
                $display("FAIL load_done: we=%b ld=%b st=%0d load_count=%0d required 0,0,0 load_count=%0d",
                         core_mem_we, core_loading, state, load_count, m_loads);
            end
        end
    endtask

    task automatic test_start();
        do_reset();
        send_cmd(2'b10, '0, '0);
        for (int k = 0; k <= HOLD; k++) begin
            vectors++;
            if (core_reset !== 1'b1 || host_ready !== 1'b0 || state !== 2'd2) begin
                errors++;
                $display("FAIL hold_phase[%0d]: rst=%b hr=%b st=%0d required 1,0,2", k, core_reset, host_ready, state);
            end
            step();
        end
        vectors++;
        if (core_reset !== 1'b0 || state !== 2'd3 || host_ready !== 1'b1) begin
            errors++;
            $display("FAIL run_entry: rst=%b st=%0d hr=%b required 0,3,1", core_reset, state, host_ready);
        end
    endtask

    task automatic test_capture();
        go_run();
        for (int i = 1; i <= 3; i++) drive_cycle(1'b1, DATA_W'(i), 1'b0);
        for (int i = 1; i <= 3; i++) begin
            vectors++;
            if (rd_valid !== 1'b1 || rd_data !== DATA_W'(i)) begin
                errors++;
                $display("FAIL capture_read[%0d]: rv=%b data=%h required 1 data=%h", i, rd_valid, rd_data, DATA_W'(i));
            end
            drive_cycle(1'b0, '0, 1'b1);
        end
        vectors++;
        if (rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL capture_empty: rv=%b required 0", rd_valid);
        end
    endtask

    task automatic test_overflow();
        go_run();
        for (int i = 1; i <= 4; i++) drive_cycle(1'b1, DATA_W'(i), 1'b0);
        drive_cycle(1'b1, 32'd5, 1'b1);
        vectors++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL full_push_with_pop: overflow=%b required 0", overflow);
        end
        drive_cycle(1'b1, 32'd6, 1'b0);
        vectors++;
        if (overflow !== 1'b1) begin
            errors++;
            $display("FAIL full_push_no_pop: overflow=%b required 1", overflow);
        end
        while (mq.size() > 0) begin
            vectors++;
            if (rd_valid !== 1'b1 || rd_data !== mq[0]) begin
                errors++;
                $display("FAIL overflow_drain: rv=%b data=%h required 1 data=%h", rd_valid, rd_data, mq[0]);
            end
            drive_cycle(1'b0, '0, 1'b1);
        end
        vectors++;
        if (rd_valid !== 1'b0 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL overflow_end: rv=%b ov=%b required 0,1", rd_valid, overflow);
        end
    endtask

    task automatic test_illegal_halt();
        go_run();
        drive_cycle(1'b1, 32'hA5A5_0001, 1'b0);
        drive_cycle(1'b1, 32'hA5A5_0002, 1'b0);
        send_cmd(2'b01, 20'h00055, 32'h12345678);
        m_err = 1'b1;
        vectors++;
        if (cmd_err !== m_err || core_mem_we !== 1'b0 || core_loading !== 1'b0 || state !== 2'd3) begin
            errors++;
            $display("FAIL illegal_load: ce=%b we=%b ld=%b st=%0d required 1,0,0,3", cmd_err, core_mem_we, core_loading, state);
        end
        send_cmd(2'b10, '0, '0);
        vectors++;
        if (state !== 2'd3 || core_reset !== 1'b0 || rd_valid !== 1'b1 || load_count !== 16'd0) begin
            errors++;
            $display("FAIL illegal_start: st=%0d rst=%b rv=%b lc=%0d required 3,0,1,0", state, core_reset, rd_valid, load_count);
        end
        send_cmd(2'b11, '0, '0);
        m_run = 1'b0;
        vectors++;
        if (state !== 2'd0 || core_reset !== 1'b1 || rd_valid !== 1'b1 || rd_data !== mq[0]) begin
            errors++;
            $display("FAIL halt: st=%0d rst=%b rv=%b data=%h required 0,1,1 data=%h", state, core_reset, rd_valid, rd_data, mq[0]);
        end
        drive_cycle(1'b1, 32'hBAD0_0000, 1'b0);
        vectors++;
        if (rd_data !== mq[0] || mq.size() != 2) begin
            errors++;
            $display("FAIL idle_push_ignored: data=%h required %h", rd_data, mq[0]);
        end
        rd_ready = 1'b1;
        send_cmd(2'b10, '0, '0);
        rd_ready = 1'b0;
        mq.delete();
        vectors++;
        if (rd_valid !== 1'b0 || state !== 2'd2) begin
            errors++;
            $display("FAIL start_clear_over_pop: rv=%b st=%0d required 0,2", rd_valid, state);
        end
    endtask

    task automatic test_random_traffic();
        logic              v;
        logic              r;
        logic [DATA_W-1:0] d;
        go_run();
        for (int i = 0; i < 400; i++) begin
            vectors++;
            if (rd_valid !== (mq.size() != 0) || overflow !== m_ovf || (mq.size() != 0 && rd_data !== mq[0])) begin
                errors++;
                $display("FAIL random_fifo[%0d]: rv=%b ov=%b data=%h required rv=%b ov=%b data=%h",
                         i, rd_valid, overflow, rd_data, mq.size() != 0, m_ovf, (mq.size() != 0) ? mq[0] : '0);
            end
            v = 1'($urandom_range(0, 1));
            r = 1'($urandom_range(0, 2) == 0);
            d = $urandom;
            drive_cycle(v, d, r);
        end
        send_cmd(2'b11, '0, '0);
        m_run = 1'b0;
        for (int i = 0; i < 8; i++) begin
            vectors++;
            if (rd_valid !== (mq.size() != 0) || (mq.size() != 0 && rd_data !== mq[0])) begin
                errors++;
                $display("FAIL idle_drain[%0d]: rv=%b data=%h required rv=%b data=%h",
                         i, rd_valid, rd_data, mq.size() != 0, (mq.size() != 0) ? mq[0] : '0);
            end
            drive_cycle(1'($urandom_range(0, 1)), $urandom, 1'b1);
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_start();
        test_capture();
        test_overflow();
        test_illegal_halt();
        test_random_traffic();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
